// File: rtl/addsub_chunked.sv
// -----------------------------------------------------------------------------
// addsub_chunked
//   Multi-cycle two's-complement adder/subtractor. Each accepted operation is
//   processed CHUNK bits per clock, LSB slice first, with a registered carry
//   between slices. It is the shared add/sub resource beside the multiplier and
//   divider datapaths.
//
// Parameters
//   WIDTH    operand/result width (multiple of CHUNK, >= 2)
//   CHUNK    bits processed per clock (1..WIDTH)
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   synchronous reset, active-high
//   start     in   request an operation (accepted only while idle)
//   op        in   0 = a + b, 1 = a - b (sampled with start)
//   a, b      in   operands (sampled with start)
//   busy      out  operation in progress
//   done      out  one-cycle pulse: result and flags just updated
//   result    out  sum/difference modulo 2^WIDTH
//   cout      out  carry out of MSB (subtract: 1 = no borrow)
//   overflow  out  signed overflow
//   zero      out  result == 0
//   negative  out  result MSB
// -----------------------------------------------------------------------------
module addsub_chunked #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_carry;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;      // already conditionally inverted for subtract
  logic [WIDTH-1:0]   r_sum;    // working sum, never visible on result

  logic [CHUNK-1:0]   w_a_sl;
  logic [CHUNK-1:0]   w_b_sl;
  logic [CHUNK-1:0]   w_sum_sl;
  logic               w_cout_sl;
  logic [WIDTH-1:0]   w_sum_next;
  logic               w_last;
  logic               w_accept;

  function automatic logic [CHUNK:0] slice_add(input logic [CHUNK-1:0] x,
                                               input logic [CHUNK-1:0] y,
                                               input logic             cin);
    return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
  endfunction

  assign w_accept = (r_state == S_IDLE) && start;

  always_comb begin
    w_a_sl                              = r_a[int'(r_cnt)*CHUNK +: CHUNK];
    w_b_sl                              = r_b[int'(r_cnt)*CHUNK +: CHUNK];
    {w_cout_sl, w_sum_sl}               = slice_add(w_a_sl, w_b_sl, r_carry);
    w_sum_next                          = r_sum;
    w_sum_next[int'(r_cnt)*CHUNK +: CHUNK] = w_sum_sl;
    w_last                              = (r_cnt == CNT_W'(NCHUNK - 1));
  end

  // Operand/working-sum registers: pure data, no reset needed.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a   <= a;
      r_b   <= b ^ {WIDTH{op}};
      r_sum <= '0;
    end else if (r_state == S_RUN) begin
      r_sum <= w_sum_next;
    end
  end

  // Control FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b1;
      negative <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            // Subtract is a + ~b + 1: the +1 enters as the initial carry.
            r_carry <= op;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_carry <= w_cout_sl;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            result   <= w_sum_next;
            cout     <= w_cout_sl;
            // Same-sign operands producing a differently-signed sum.
            overflow <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                        (w_sum_sl[CHUNK-1] != r_a[WIDTH-1]);
            zero     <= (w_sum_next == '0);
            negative <= w_sum_next[WIDTH-1];
            done     <= 1'b1;
            busy     <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
